// File: rtl/state_arb_pkg.sv
// state_arb_pkg: shared definitions for the game-state RAM arbiter.
//   - Default geometry of the game-state RAM, shared with the VGA top and game logic.
//   - FSM state encoding for the arbiter's game-side FSM.
package state_arb_pkg;

   localparam int unsigned DefAddrW = 10;
   localparam int unsigned DefDataW = 8;
   localparam int unsigned DefDepth = 1024;

   typedef enum logic [1:0] {
      StIdle,
      StAck,
      StClear
   } arb_state_e;

endpackage

// File: rtl/state_ram_clear_seq.sv
// state_ram_clear_seq: board-clear sequencer for the game-state RAM.
// Walks an index from 0 to DEPTH-1, requesting one write per cycle unless stalled by a VGA
// read. Only instantiated when STATE_RAM_ARB_CLEAR_EN is defined.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   start       - begin a clear (ignored while busy)
//   stall       - VGA read owns the RAM this cycle
//   busy        - clear in progress
//   done        - one-cycle pulse in the cycle the last word is written
//   wr_en       - write CLEAR_VALUE at idx this cycle
//   idx         - current clear index
module state_ram_clear_seq
   import state_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DEPTH  = DefDepth
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] idx
);

   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              last;

   always_comb begin
      wr_en  = busy_q & ~stall;
      last   = (idx_q == ADDR_W'(DEPTH - 1));
      done   = wr_en & last;
      busy_d = busy_q;
      idx_d  = idx_q;
      if (start && !busy_q) begin
         busy_d = 1'b1;
      end
      if (wr_en) begin
         if (last) begin
            busy_d = 1'b0;
            idx_d  = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         idx_q  <= '0;
      end else begin
         busy_q <= busy_d;
         idx_q  <= idx_d;
      end
   end

   assign busy = busy_q;
   assign idx  = idx_q;

endmodule

// File: rtl/state_ram_arbiter.sv
// state_ram_arbiter: shares the single-port synchronous-read game-state RAM between the VGA
// pixel pipeline (absolute priority, never stalled) and the snake game-logic engine.
// Optional board-clear sequencer built when macro STATE_RAM_ARB_CLEAR_EN is defined; otherwise
// clear_start is ignored and clear_busy/clear_done are tied low.
// Ports:
//   clk, reset                      - clock, asynchronous active-low reset
//   vga_re, vga_raddr, vga_rdata    - VGA read port, data valid the cycle after vga_re
//   game_req/we/addr/wdata          - game request, held until game_ack
//   game_ack, game_rdata            - completion pulse and read data (held until next read)
//   clear_start/busy/done           - board clear control and status
//   mem_en/we/addr/wdata, mem_rdata - RAM port
module state_ram_arbiter
   import state_arb_pkg::*;
#(
   parameter int unsigned      ADDR_W      = DefAddrW,
   parameter int unsigned      DATA_W      = DefDataW,
   parameter int unsigned      DEPTH       = DefDepth,
   parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vga_re,
   input  logic [ADDR_W-1:0] vga_raddr,
   output logic [DATA_W-1:0] vga_rdata,
   input  logic              game_req,
   input  logic              game_we,
   input  logic [ADDR_W-1:0] game_addr,
   input  logic [DATA_W-1:0] game_wdata,
   output logic              game_ack,
   output logic [DATA_W-1:0] game_rdata,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic              clear_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        state_q, state_d;
   logic              grant;
   logic              rd_pend_q;  // previous cycle's RAM read belonged to the game
   logic [DATA_W-1:0] hold_q;
   logic              clr_req, clr_start_seq, clr_wr, clr_busy, clr_done;
   logic [ADDR_W-1:0] clr_idx;

`ifdef STATE_RAM_ARB_CLEAR_EN
   logic pend_q, pend_d;

   // A clear_start arriving during the ack cycle is remembered for the next idle cycle.
   always_comb begin
      pend_d = pend_q;
      if (state_q == StAck && clear_start) begin
         pend_d = 1'b1;
      end else if (clr_start_seq) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign clr_req = pend_q | clear_start;

   state_ram_clear_seq #(
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) u_clear_seq (
      .clk  (clk),
      .reset(reset),
      .start(clr_start_seq),
      .stall(vga_re),
      .busy (clr_busy),
      .done (clr_done),
      .wr_en(clr_wr),
      .idx  (clr_idx)
   );
`else
   logic        unused_clear;
   logic [31:0] unused_depth;

   assign clr_req      = 1'b0;
   assign clr_wr       = 1'b0;
   assign clr_busy     = 1'b0;
   assign clr_done     = 1'b0;
   assign clr_idx      = '0;
   assign unused_clear = clear_start ^ clr_start_seq;
   assign unused_depth = DEPTH;
`endif

   always_comb begin
      state_d       = state_q;
      grant         = 1'b0;
      clr_start_seq = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (clr_req) begin
               state_d       = StClear;
               clr_start_seq = 1'b1;
            end else if (game_req && !vga_re) begin
               grant   = 1'b1;
               state_d = StAck;
            end
         end
         StAck:   state_d = StIdle;  // no grant here: a still-high game_req is not re-served
         StClear: if (clr_done) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         rd_pend_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         rd_pend_q <= grant & ~game_we;
         if (rd_pend_q) begin
            hold_q <= mem_rdata;
         end
      end
   end

   // VGA wins the port outright; clear writes and game grants only use cycles it leaves free.
   always_comb begin
      mem_en    = vga_re | clr_wr | grant;
      mem_we    = ~vga_re & (clr_wr | (grant & game_we));
      mem_addr  = '0;
      mem_wdata = '0;
      if (vga_re) begin
         mem_addr = vga_raddr;
      end else if (clr_wr) begin
         mem_addr  = clr_idx;
         mem_wdata = CLEAR_VALUE;
      end else if (grant) begin
         mem_addr = game_addr;
         if (game_we) begin
            mem_wdata = game_wdata;
         end
      end
   end

   assign vga_rdata  = mem_rdata;
   assign game_ack   = (state_q == StAck);
   assign game_rdata = rd_pend_q ? mem_rdata : hold_q;
   assign clear_busy = clr_busy;
   assign clear_done = clr_done;

endmodule

// File: tb/tb_state_ram_arbiter.sv
// Bench for state_ram_arbiter: a behavioural RAM plus a reference model (shadow memory and
// transaction rules) checked every cycle, directed scenarios with literal expectations, and a
// randomized phase.
module tb_state_ram_arbiter;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int DEPTH = 1024;
   localparam logic [DW-1:0] CLR_VAL = 8'h00;
`ifdef STATE_RAM_ARB_CLEAR_EN
   localparam bit ClearEn = 1'b1;
   localparam int ClearWinsLat = DEPTH + 3;
`else
   localparam bit ClearEn = 1'b0;
   localparam int ClearWinsLat = 2;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          vga_re = 1'b0;
   logic [AW-1:0] vga_raddr = '0;
   logic [DW-1:0] vga_rdata;
   logic          game_req = 1'b0;
   logic          game_we = 1'b0;
   logic [AW-1:0] game_addr = '0;
   logic [DW-1:0] game_wdata = '0;
   logic          game_ack;
   logic [DW-1:0] game_rdata;
   logic          clear_start = 1'b0;
   logic          clear_busy, clear_done;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   state_ram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .vga_re     (vga_re),
      .vga_raddr  (vga_raddr),
      .vga_rdata  (vga_rdata),
      .game_req   (game_req),
      .game_we    (game_we),
      .game_addr  (game_addr),
      .game_wdata (game_wdata),
      .game_ack   (game_ack),
      .game_rdata (game_rdata),
      .clear_start(clear_start),
      .clear_busy (clear_busy),
      .clear_done (clear_done),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural RAM with a preload port used only while the DUT is held in reset.
   logic [DW-1:0] ram [DEPTH];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) begin
         ram[pl_addr] <= pl_data;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model state.
   logic [DW-1:0] shadow [DEPTH];
   bit            m_ack = 1'b0;
   bit            m_ack_rd = 1'b0;
   logic [DW-1:0] m_ack_data = '0;
   logic [DW-1:0] m_grdata = '0;
   bit            m_vga_v = 1'b0;
   logic [DW-1:0] m_vga_d = '0;
   bit            m_clr = 1'b0;
   int            m_idx = 0;
   bit            m_pend = 1'b0;
   int            cyc = 0;
   bit            last_ack = 1'b0;
   int            dut_done_cnt = 0;

   // Compare process: checks all outputs each cycle, then advances the model past the edge.
   initial begin
      bit g, cw, cs, e_en, e_we, e_done;
      int e_addr;
      logic [DW-1:0] e_wd;
      forever begin
         @(negedge clk);
         cyc++;
         last_ack = game_ack;
         if (clear_done) dut_done_cnt++;
         if (!reset) begin
            m_ack = 0; m_clr = 0; m_idx = 0; m_pend = 0; m_grdata = '0;
            chk("rst_game_ack", 32'(game_ack), 0);
            chk("rst_game_rdata", 32'(game_rdata), 0);
            chk("rst_clear_busy", 32'(clear_busy), 0);
            chk("rst_clear_done", 32'(clear_done), 0);
            chk("rst_mem_en", 32'(mem_en), 32'(vga_re));
            chk("rst_mem_we", 32'(mem_we), 0);
            m_vga_v = vga_re;
            if (vga_re) m_vga_d = shadow[vga_raddr];
         end else begin
            if (m_vga_v) chk("vga_rdata", 32'(vga_rdata), 32'(m_vga_d));
            chk("game_ack", 32'(game_ack), 32'(m_ack));
            if (m_ack && m_ack_rd) m_grdata = m_ack_data;
            chk("game_rdata", 32'(game_rdata), 32'(m_grdata));
            g = 0; cw = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = '0;
            cs = ClearEn && !m_ack && !m_clr && (m_pend || clear_start);
            if (vga_re) begin
               e_en = 1; e_addr = int'(vga_raddr);
            end else if (m_clr) begin
               cw = 1; e_en = 1; e_we = 1; e_addr = m_idx; e_wd = CLR_VAL;
            end else if (game_req && !m_ack && !cs) begin
               g = 1; e_en = 1; e_we = game_we; e_addr = int'(game_addr); e_wd = game_wdata;
            end
            e_done = cw && (m_idx == DEPTH - 1);
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            chk("clear_busy", 32'(clear_busy), 32'(m_clr));
            chk("clear_done", 32'(clear_done), 32'(e_done));
            m_vga_v = vga_re;
            if (vga_re) m_vga_d = shadow[vga_raddr];
            if (g) begin
               m_ack_rd   = !game_we;
               m_ack_data = shadow[game_addr];
               if (game_we) shadow[game_addr] = game_wdata;
            end
            if (cw) begin
               shadow[m_idx] = CLR_VAL;
               if (e_done) begin m_clr = 0; m_idx = 0; end
               else m_idx++;
            end
            if (ClearEn && m_ack && clear_start) m_pend = 1;
            if (cs) begin m_clr = 1; m_pend = 0; end
            m_ack = g;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic game_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [DW-1:0] rd);
      game_req = 1'b1; game_we = we; game_addr = a; game_wdata = d;
      lat = 0; rd = '0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (game_ack) begin
            rd = game_rdata;
            break;
         end
         if (lat >= 5000) begin
            tests++; fails++;
            $display("FAIL game_timeout: no ack after %0d cycles, required an ack", lat);
            break;
         end
      end
      @(posedge clk);
      #1;
      game_req = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [DW-1:0] rd;
      // Preload RAM and shadow with random contents while in reset.
      pl_en = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         pl_addr = AW'(i);
         pl_data = DW'($urandom);
         shadow[i] = pl_data;
         @(posedge clk);
         #1;
      end
      pl_en = 1'b0;
      // VGA path stays live in reset.
      vga_re = 1'b1; vga_raddr = 10'h003;
      @(negedge clk);
      chk("rst_vga_live", 32'(mem_en), 1);
      tick();
      vga_re = 1'b0;
      tick();
      reset = 1'b1;
      tick();

      // Read / write / read of 0x05.
      game_op(1'b0, 10'h005, 8'h00, lat, rd);
      chk("rd1_lat", 32'(lat), 2);
      game_op(1'b1, 10'h005, 8'hA3, lat, rd);
      chk("wr_lat", 32'(lat), 2);
      game_op(1'b0, 10'h005, 8'h00, lat, rd);
      chk("rd2_lat", 32'(lat), 2);
      chk("rd2_data", 32'(rd), 32'h0A3);
      tick();
      chk("rdata_held", 32'(game_rdata), 32'h0A3);

      // 20-cycle VGA burst while a game read waits.
      vga_re = 1'b1;
      fork
         game_op(1'b0, 10'h005, 8'h00, lat, rd);
         begin
            for (int i = 0; i < 20; i++) begin
               vga_raddr = AW'($urandom);
               tick();
            end
            vga_re = 1'b0;
         end
      join
      chk("burst_lat", 32'(lat), 22);
      chk("burst_data", 32'(rd), 32'h0A3);

      // VGA read of 0x3FF in the game read's ack cycle.
      game_op(1'b1, 10'h3FF, 8'h5C, lat, rd);
      chk("wr3ff_lat", 32'(lat), 2);
      fork
         game_op(1'b0, 10'h005, 8'h00, lat, rd);
         begin
            tick();
            vga_re = 1'b1; vga_raddr = 10'h3FF;
            tick();
            vga_re = 1'b0;
            @(negedge clk);
            chk("vga_3ff_data", 32'(vga_rdata), 32'h05C);
         end
      join
      chk("ackcyc_game_data", 32'(rd), 32'h0A3);
      tick();

      // clear_start together with game_req.
      fork
         game_op(1'b0, 10'h3FF, 8'h00, lat, rd);
         begin
            clear_start = 1'b1;
            tick();
            clear_start = 1'b0;
         end
      join
      chk("clear_wins_lat", 32'(lat), 32'(ClearWinsLat));
      chk("clear_wins_data", 32'(rd), ClearEn ? 32'(CLR_VAL) : 32'h05C);
      tick();

`ifdef STATE_RAM_ARB_CLEAR_EN
      begin
         int cnt, done_cyc, ack_cyc;
         bit got;
         // Clear with 50% VGA traffic, game read issued during the clear.
         clear_start = 1'b1;
         tick();
         clear_start = 1'b0;
         cnt = 0; done_cyc = 0; ack_cyc = 0; got = 0;
         fork
            begin
               while (cnt < 5000) begin
                  vga_re = ~vga_re;
                  vga_raddr = AW'($urandom);
                  @(negedge clk);
                  cnt++;
                  if (clear_done) begin got = 1; done_cyc = cyc; break; end
                  @(posedge clk);
                  #1;
               end
               @(posedge clk);
               #1;
               vga_re = 1'b0;
            end
            begin
               repeat (10) tick();
               game_op(1'b0, 10'h007, 8'h00, lat, rd);
               ack_cyc = cyc;
            end
         join
         chk("clear50_done_seen", 32'(got), 1);
         chk("clear50_len_ok", 32'(cnt >= 2040 && cnt <= 2056), 1);
         chk("game_after_done", 32'(ack_cyc > done_cyc), 1);
         chk("game_read_cleared", 32'(rd), 32'(CLR_VAL));
         for (int a = 0; a < DEPTH; a++) begin
            vga_re = 1'b1; vga_raddr = AW'(a);
            tick();
            vga_re = 1'b0;
            @(negedge clk);
            chk("cleared_word", 32'(vga_rdata), 0);
            tick();
         end

         // Reset mid-clear at index 300.
         clear_start = 1'b1;
         tick();
         clear_start = 1'b0;
         cnt = 0;
         while (m_idx != 300 && cnt < 2000) begin tick(); cnt++; end
         chk("reached_idx300", 32'(m_idx), 300);
         reset = 1'b0;
         #1;
         chk("abort_busy", 32'(clear_busy), 0);
         chk("abort_done", 32'(clear_done), 0);
         chk("abort_mem_en", 32'(mem_en), 0);
         chk("abort_mem_we", 32'(mem_we), 0);
         tick();
         tick();
         reset = 1'b1;
         cnt = dut_done_cnt;
         repeat (1100) tick();
         chk("no_done_after_abort", 32'(dut_done_cnt - cnt), 0);
         clear_start = 1'b1;
         tick();
         clear_start = 1'b0;
         @(negedge clk);
         chk("restart_idx0", 32'(mem_addr), 0);
         chk("restart_we", 32'(mem_we), 1);
         cnt = 0;
         while (clear_busy && cnt < 3000) begin tick(); cnt++; end
         chk("restart_finished", 32'(clear_busy), 0);
         tick();
      end
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         vga_re      = ($urandom_range(99) < 40);
         vga_raddr   = ($urandom_range(1) == 1) ? AW'($urandom_range(15)) : AW'($urandom);
         clear_start = ($urandom_range(399) == 0);
         if (game_req && last_ack) game_req = 1'b0;
         if (!game_req && $urandom_range(99) < 35) begin
            game_req   = 1'b1;
            game_we    = 1'($urandom_range(1));
            game_addr  = AW'($urandom_range(15));
            game_wdata = DW'($urandom);
         end
         tick();
      end
      vga_re = 1'b0; clear_start = 1'b0; game_req = 1'b0;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
